// File: rtl/bin_mult.sv
// Pipelined unsigned shift-add multiplier: each stage folds WIDTH/STAGES bits of B
// into a running 2*WIDTH-bit accumulator, giving one product per cycle.
module bin_mult #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] C
);

  localparam int K  = WIDTH / STAGES;
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_reg    [0:STAGES-1];
  logic [WIDTH-1:0] b_reg    [0:STAGES-1];
  logic [PW-1:0]    acc_reg  [0:STAGES];
  logic [PW-1:0]    acc_next [1:STAGES];

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      logic [K-1:0]  b_slice;
      logic [PW-1:0] a_ext;
      logic [PW-1:0] pp;

      assign b_slice = b_reg[gi-1][(gi-1)*K +: K];
      assign a_ext   = {{WIDTH{1'b0}}, a_reg[gi-1]};

      // Partial product as a sum of K AND-gated, shifted copies of A.
      always_comb begin
        pp = '0;
        for (int j = 0; j < K; j++) begin
          pp = pp + ((a_ext & {PW{b_slice[j]}}) << j);
        end
      end

      assign acc_next[gi] = acc_reg[gi-1] + (pp << ((gi-1)*K));
    end
  endgenerate

  // rst_n is active-high despite its name.
  always_ff @(posedge CLK or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
      for (int i = 0; i <= STAGES; i++) begin
        acc_reg[i] <= '0;
      end
    end else begin
      a_reg[0]   <= A;
      b_reg[0]   <= B;
      acc_reg[0] <= '0;
      for (int i = 1; i < STAGES; i++) begin
        a_reg[i] <= a_reg[i-1];
        b_reg[i] <= b_reg[i-1];
      end
      for (int i = 1; i <= STAGES; i++) begin
        acc_reg[i] <= acc_next[i];
      end
    end
  end

  assign C = acc_reg[STAGES];

endmodule

// File: tb/tb_bin_mult.sv
// Directed and streaming checks of bin_mult at the default size plus two
// alternative WIDTH/STAGES configurations driven in parallel.
module tb_bin_mult;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int W1 = 16;
  localparam int S1 = 2;
  localparam int W2 = 32;
  localparam int S2 = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    a, b;
  logic [2*W-1:0]  c;
  logic [W1-1:0]   a1, b1;
  logic [2*W1-1:0] c1;
  logic [W2-1:0]   a2, b2;
  logic [2*W2-1:0] c2;

  always #5 clk = ~clk;

  bin_mult #(.WIDTH(W), .STAGES(S)) dut (
    .CLK(clk), .rst_n(rst), .A(a), .B(b), .C(c)
  );
  bin_mult #(.WIDTH(W1), .STAGES(S1)) dut16 (
    .CLK(clk), .rst_n(rst), .A(a1), .B(b1), .C(c1)
  );
  bin_mult #(.WIDTH(W2), .STAGES(S2)) dut8 (
    .CLK(clk), .rst_n(rst), .A(a2), .B(b2), .C(c2)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    string       name;
  } vec_t;

  vec_t        corners [8];
  int          checks   = 0;
  int          failures = 0;
  bit          sweep_en = 1'b0;
  logic [63:0] exp_q  [$];
  string       name_q [$];
  logic [31:0] q1     [$];
  logic [63:0] q2     [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Pipeline contents are all zero after reset with zero inputs.
  task automatic prefill();
    exp_q.delete();
    name_q.delete();
    q1.delete();
    q2.delete();
    repeat (S + 1) begin
      exp_q.push_back(64'd0);
      name_q.push_back("idle");
    end
    repeat (S1 + 1) q1.push_back(32'd0);
    repeat (S2 + 1) q2.push_back(64'd0);
  endtask

  // One clock: check the product due now, then drive the next operand pair.
  task automatic cycle(input logic [31:0] na, input logic [31:0] nb,
                       input logic [63:0] np, input string nm);
    logic [63:0] e;
    string       en;
    logic [15:0] r1a, r1b;
    logic [31:0] r2a, r2b;
    @(negedge clk);
    e  = exp_q.pop_front();
    en = name_q.pop_front();
    chk(en, c, e);
    $display("txn %s a=%h b=%h c=%h exp=%h", en, a, b, c, e);
    chk("sweep_w16_s2", {32'd0, c1}, {32'd0, q1.pop_front()});
    chk("sweep_w32_s8", c2, q2.pop_front());
    a = na;
    b = nb;
    exp_q.push_back(np);
    name_q.push_back(nm);
    if (sweep_en) begin
      r1a = 16'($urandom);
      r1b = 16'($urandom);
      r2a = $urandom;
      r2b = $urandom;
    end else begin
      r1a = '0; r1b = '0; r2a = '0; r2b = '0;
    end
    a1 = r1a;
    b1 = r1b;
    a2 = r2a;
    b2 = r2b;
    q1.push_back(32'(r1a) * 32'(r1b));
    q2.push_back(64'(r2a) * 64'(r2b));
  endtask

  initial begin
    logic [31:0] ra, rb;

    corners[0] = '{32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, "zero_a"};
    corners[1] = '{32'h0000_0001, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF, "one_a"};
    corners[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max_max"};
    corners[3] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, "msb_x2"};
    corners[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 64'h0000_0000_0000_0000, "zero_b"};
    corners[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, "ffff_sq"};
    corners[6] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, "shift4"};
    corners[7] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "msb_sq"};

    rst = 1'b1;
    a = '0; b = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (4) @(negedge clk);
    chk("reset_hold", c, 64'd0);
    chk("reset_hold_w16", {32'd0, c1}, 64'd0);
    chk("reset_hold_w32_s8", c2, 64'd0);

    rst = 1'b0;
    prefill();
    cycle(32'd0, 32'd0, 64'd0, "pre0");
    cycle(32'd0, 32'd0, 64'd0, "pre1");
    repeat (S + 3) cycle(32'd2, 32'd2, 64'd4, "two_by_two");

    for (int i = 0; i < 8; i++) begin
      cycle(corners[i].a, corners[i].b, corners[i].p, corners[i].name);
    end

    sweep_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      cycle(ra, rb, 64'(ra) * 64'(rb), "stream");
    end
    sweep_en = 1'b0;

    repeat (S + 1) cycle(32'd6, 32'd7, 64'd42, "six_by_seven");
    cycle(32'd7, 32'd9, 64'd63, "inflight0");
    cycle(32'd11, 32'd13, 64'd143, "inflight1");
    cycle(32'd5, 32'd5, 64'd25, "inflight2");

    // Reset lands between edges while newer products are still in flight.
    @(posedge clk);
    #1;
    chk("midrst_pre", c, 64'd42);
    #2;
    rst = 1'b1;
    a = '0; b = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    #1;
    chk("midrst_async", c, 64'd0);
    chk("midrst_async_w16", {32'd0, c1}, 64'd0);
    chk("midrst_async_w32_s8", c2, 64'd0);
    repeat (2) @(negedge clk);
    chk("midrst_hold", c, 64'd0);
    rst = 1'b0;
    prefill();
    cycle(32'd0, 32'd0, 64'd0, "post0");
    cycle(32'd9, 32'd9, 64'd81, "post_first");
    repeat (S + 2) cycle(32'd0, 32'd0, 64'd0, "flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
